// File: rtl/i2c_reg_target_pkg.sv
// Shared definitions for the I2C register target: FSM states, widths,
// default device address and the register-pointer increment helper.
package i2c_reg_target_pkg;

  localparam int REG_WIDTH = 8;
  localparam int PTR_WIDTH = 8;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h70;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  // Advance the register pointer, wrapping to 0 after the last mapped register
  // (an out-of-range pointer also wraps back to 0).
  function automatic logic [PTR_WIDTH-1:0] ptrInc(input logic [PTR_WIDTH-1:0] p,
                                                  input int numRegs);
    if ({{(32-PTR_WIDTH){1'b0}}, p} >= 32'(numRegs - 1))
      return '0;
    else
      return p + PTR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/i2c_reg_target_if.sv
// I2C pin bundle as seen by the target: synchronized SCL/SDA in,
// open-drain SDA drive (value is always 0, only the enable matters) out.
interface i2c_reg_target_if;

  logic scl;
  logic sda_i;
  logic sda_o;
  logic sda_oe;

  modport slave (
    input  scl,
    input  sda_i,
    output sda_o,
    output sda_oe
  );

  modport master (
    output scl,
    output sda_i,
    input  sda_o,
    input  sda_oe
  );

endinterface

// File: rtl/i2c_bus_events.sv
// Bus event detector: keeps the previous SCL/SDA samples and flags
// START, STOP and SCL edges as single-cycle pulses.
module i2c_bus_events (
  input  logic clk,
  input  logic rstb,
  input  logic i_ena,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_sclRise,
  output logic o_sclFall
);

  logic r_sclQ;
  logic r_sdaQ;

  // Previous-cycle samples; reset high so an idle bus never looks like a START.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sclQ <= 1'b1;
      r_sdaQ <= 1'b1;
    end else if (i_ena) begin
      r_sclQ <= i_scl;
      r_sdaQ <= i_sda;
    end
  end

  assign o_start   = r_sclQ &  r_sdaQ & ~i_sda;
  assign o_stop    = r_sclQ & ~r_sdaQ &  i_sda;
  assign o_sclRise = ~r_sclQ &  i_scl;
  assign o_sclFall =  r_sclQ & ~i_scl;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target giving an external controller read/write access to the
// config register bank and read access to the status bank.
module i2c_reg_target
  import i2c_reg_target_pkg::*;
#(
  parameter int         NUM_CFG    = 8,
  parameter int         NUM_STATUS = 8,
  parameter int         REG_WIDTH  = i2c_reg_target_pkg::REG_WIDTH,
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic                            i2c_en,
  i2c_reg_target_if.slave                 bus,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int NUM_REGS = NUM_CFG + NUM_STATUS;
  localparam logic [PTR_WIDTH-1:0] CFG_LIMIT = PTR_WIDTH'(NUM_CFG);

  state_t                       r_state, w_stateNext;
  logic [2:0]                   r_bitCnt, w_bitCntNext;
  logic [REG_WIDTH-1:0]         r_shift, w_shiftNext;
  logic [PTR_WIDTH-1:0]         r_ptr, w_ptrNext;
  logic                         r_sdaOe, w_sdaOeNext;
  logic                         w_cfgWe;
  logic [NUM_CFG*REG_WIDTH-1:0] r_cfg;
  logic [REG_WIDTH-1:0]         w_byteIn;
  logic [REG_WIDTH-1:0]         w_rdData;
  logic                         w_start, w_stop, w_sclRise, w_sclFall;

  i2c_bus_events u_events (
    .clk       (clk),
    .rstb      (rstb),
    .i_ena     (ena),
    .i_scl     (bus.scl),
    .i_sda     (bus.sda_i),
    .o_start   (w_start),
    .o_stop    (w_stop),
    .o_sclRise (w_sclRise),
    .o_sclFall (w_sclFall)
  );

  assign w_byteIn = {r_shift[REG_WIDTH-2:0], bus.sda_i};

  // Register at the current pointer; anything outside the map reads as zero.
  always_comb begin
    w_rdData = '0;
    for (int k = 0; k < NUM_CFG; k++)
      if (r_ptr == PTR_WIDTH'(k))
        w_rdData = r_cfg[k*REG_WIDTH +: REG_WIDTH];
    for (int k = 0; k < NUM_STATUS; k++)
      if (r_ptr == PTR_WIDTH'(NUM_CFG + k))
        w_rdData = status_regs[k*REG_WIDTH +: REG_WIDTH];
  end

  // Protocol FSM: bit counter doubles as the "ACK already driven" flag in ACK states.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_ptrNext    = r_ptr;
    w_sdaOeNext  = r_sdaOe;
    w_cfgWe      = 1'b0;

    if (!i2c_en) begin
      w_stateNext  = ST_IDLE;
      w_bitCntNext = '0;
      w_sdaOeNext  = 1'b0;
    end else if (w_start) begin
      w_stateNext  = ST_ADDR;
      w_bitCntNext = '0;
      w_sdaOeNext  = 1'b0;
    end else if (w_stop) begin
      w_stateNext  = ST_IDLE;
      w_bitCntNext = '0;
      w_sdaOeNext  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_sclRise) begin
            w_shiftNext  = w_byteIn;
            w_bitCntNext = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7)
              w_stateNext = (w_byteIn[REG_WIDTH-1:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          end
        end
        ST_ADDR_ACK: begin
          if (w_sclFall) begin
            if (r_bitCnt == 3'd0) begin
              w_sdaOeNext  = 1'b1;
              w_bitCntNext = 3'd1;
            end else begin
              w_bitCntNext = '0;
              if (r_shift[0]) begin
                w_shiftNext = w_rdData;
                w_sdaOeNext = ~w_rdData[REG_WIDTH-1];
                w_stateNext = ST_RD;
              end else begin
                w_sdaOeNext = 1'b0;
                w_stateNext = ST_PTR;
              end
            end
          end
        end
        ST_PTR: begin
          if (w_sclRise) begin
            w_shiftNext  = w_byteIn;
            w_bitCntNext = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              w_ptrNext   = w_byteIn;
              w_stateNext = ST_PTR_ACK;
            end
          end
        end
        ST_WR: begin
          if (w_sclRise) begin
            w_shiftNext  = w_byteIn;
            w_bitCntNext = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              w_cfgWe     = (r_ptr < CFG_LIMIT);
              w_ptrNext   = ptrInc(r_ptr, NUM_REGS);
              w_stateNext = ST_WR_ACK;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (w_sclFall) begin
            if (r_bitCnt == 3'd0) begin
              w_sdaOeNext  = 1'b1;
              w_bitCntNext = 3'd1;
            end else begin
              w_sdaOeNext  = 1'b0;
              w_bitCntNext = '0;
              w_stateNext  = ST_WR;
            end
          end
        end
        ST_RD: begin
          if (w_sclFall) begin
            if (r_bitCnt == 3'd7) begin
              w_sdaOeNext  = 1'b0;
              w_bitCntNext = '0;
              w_stateNext  = ST_RD_ACK;
            end else begin
              w_shiftNext  = {r_shift[REG_WIDTH-2:0], r_shift[REG_WIDTH-1]};
              w_sdaOeNext  = ~r_shift[REG_WIDTH-2];
              w_bitCntNext = r_bitCnt + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_sclRise) begin
            if (bus.sda_i) begin
              w_stateNext = ST_IGNORE;
            end else begin
              w_ptrNext    = ptrInc(r_ptr, NUM_REGS);
              w_bitCntNext = 3'd1;
            end
          end else if (w_sclFall && r_bitCnt == 3'd1) begin
            w_shiftNext  = w_rdData;
            w_sdaOeNext  = ~w_rdData[REG_WIDTH-1];
            w_bitCntNext = '0;
            w_stateNext  = ST_RD;
          end
        end
        default: begin
          w_sdaOeNext = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sdaOe  <= 1'b0;
      r_cfg    <= '0;
    end else if (ena) begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_ptr    <= w_ptrNext;
      r_sdaOe  <= w_sdaOeNext;
      for (int k = 0; k < NUM_CFG; k++)
        if (w_cfgWe && r_ptr == PTR_WIDTH'(k))
          r_cfg[k*REG_WIDTH +: REG_WIDTH] <= w_byteIn;
    end
  end

  assign bus.sda_o   = 1'b0;
  assign bus.sda_oe  = r_sdaOe & i2c_en;
  assign config_regs = r_cfg;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged I2C controller with an
// open-drain SDA model and hand-computed expected register/bus values.
module tb_i2c_reg_target;

  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic        i2c_en;
  logic        ctrlSda;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  int          checkCount = 0;
  int          passCount  = 0;
  int          oeCount    = 0;
  int          base;
  logic        ack;
  logic [7:0]  rd;

  i2c_reg_target_if bus ();

  assign bus.sda_i = ctrlSda & ~bus.sda_oe;

  i2c_reg_target #(
    .NUM_CFG    (8),
    .NUM_STATUS (8),
    .REG_WIDTH  (8),
    .DEV_ADDR   (7'h70)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .i2c_en      (i2c_en),
    .bus         (bus),
    .config_regs (config_regs),
    .status_regs (status_regs)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Count every cycle the target pulls SDA low
  always @(posedge clk) if (bus.sda_oe === 1'b1) oeCount <= oeCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic startCond();
    ctrlSda = 1'b1; waitClk(Q);
    bus.scl = 1'b1; waitClk(Q);
    ctrlSda = 1'b0; waitClk(Q);
    bus.scl = 1'b0; waitClk(Q);
  endtask

  task automatic stopCond();
    ctrlSda = 1'b0; waitClk(Q);
    bus.scl = 1'b1; waitClk(Q);
    ctrlSda = 1'b1; waitClk(Q);
  endtask

  task automatic clockBit(input logic b, output logic line);
    ctrlSda = b;    waitClk(Q);
    bus.scl = 1'b1; waitClk(Q);
    line = bus.sda_i; waitClk(Q);
    bus.scl = 1'b0; waitClk(Q);
  endtask

  task automatic sendBits(input logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) clockBit(d[i], l);
  endtask

  task automatic getAck(output logic a);
    logic l;
    clockBit(1'b1, l);
    a = ~l;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic a);
    sendBits(d);
    getAck(a);
  endtask

  task automatic readByte(input logic ackBit, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, l);
      d[i] = l;
    end
    clockBit(ackBit, l);
  endtask

  // Full write transaction: address, pointer, then n data bytes, every byte ACKed
  task automatic applyStimulus(input string tag, input logic [7:0] ptr,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input int n);
    logic a;
    logic [7:0] d;
    startCond();
    sendByte(8'hE0, a); checkOutput({tag, "_addrAck"}, a, 1'b1);
    sendByte(ptr, a);   checkOutput({tag, "_ptrAck"}, a, 1'b1);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      sendByte(d, a);
      checkOutput({tag, "_dataAck"}, a, 1'b1);
    end
    stopCond();
  endtask

  initial begin
    rstb        = 1'b0;
    ena         = 1'b1;
    i2c_en      = 1'b1;
    bus.scl     = 1'b1;
    ctrlSda     = 1'b1;
    status_regs = {8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h10, 8'hCA};
    waitClk(5);
    checkOutput("rstCfg", config_regs, 64'h0);
    checkOutput("rstOe", bus.sda_oe, 1'b0);
    checkOutput("rstSdaO", bus.sda_o, 1'b0);
    rstb = 1'b1;
    waitClk(5);

    $display("[TB] single write 0xA5 to reg0");
    startCond();
    sendByte(8'hE0, ack); checkOutput("wrAddrAck", ack, 1'b1);
    sendByte(8'h00, ack); checkOutput("wrPtrAck", ack, 1'b1);
    sendBits(8'hA5);
    checkOutput("cfgBeforeAck", config_regs[7:0], 8'hA5);
    getAck(ack);          checkOutput("wrDataAck", ack, 1'b1);
    stopCond();
    checkOutput("cfgAfterWrite", config_regs, 64'h0000_0000_0000_00A5);

    $display("[TB] read status with repeated start");
    startCond();
    sendByte(8'hE0, ack); checkOutput("rdAddrWAck", ack, 1'b1);
    sendByte(8'h08, ack); checkOutput("rdPtrAck", ack, 1'b1);
    startCond();
    sendByte(8'hE1, ack); checkOutput("rdAddrRAck", ack, 1'b1);
    readByte(1'b0, rd);   checkOutput("rdByte0", rd, 8'hCA);
    readByte(1'b1, rd);   checkOutput("rdByte1", rd, 8'h10);
    waitClk(2);
    checkOutput("oeAfterNack", bus.sda_oe, 1'b0);
    base = oeCount;
    stopCond();
    checkOutput("oeQuietStop", oeCount - base, 0);

    $display("[TB] burst write across config/status boundary");
    applyStimulus("burst", 8'h06, 8'h11, 8'h22, 8'h33, 3);
    checkOutput("cfgAfterBurst", config_regs, 64'h2211_0000_0000_00A5);
    startCond();
    sendByte(8'hE1, ack); checkOutput("ptrRdAck", ack, 1'b1);
    readByte(1'b1, rd);   checkOutput("ptrAfterBurst", rd, 8'h10);
    stopCond();

    $display("[TB] wrong device address");
    base = oeCount;
    startCond();
    sendByte(8'hC0, ack); checkOutput("wrongAddrAck", ack, 1'b0);
    sendByte(8'h55, ack); checkOutput("wrongDataAck", ack, 1'b0);
    stopCond();
    checkOutput("wrongOeCount", oeCount - base, 0);
    checkOutput("wrongCfg", config_regs, 64'h2211_0000_0000_00A5);

    $display("[TB] reset in the middle of a data byte");
    startCond();
    sendByte(8'hE0, ack); checkOutput("midAddrAck", ack, 1'b1);
    sendByte(8'h02, ack); checkOutput("midPtrAck", ack, 1'b1);
    for (int i = 0; i < 4; i++) clockBit(1'b1, ack);
    rstb = 1'b0;
    waitClk(3);
    checkOutput("midRstCfg", config_regs, 64'h0);
    checkOutput("midRstOe", bus.sda_oe, 1'b0);
    rstb = 1'b1;
    waitClk(4);
    applyStimulus("wrap", 8'h0F, 8'h99, 8'h5A, 8'h00, 2);
    checkOutput("cfgAfterWrap", config_regs, 64'h0000_0000_0000_005A);

    $display("[TB] peripheral deselect during a read");
    startCond();
    sendByte(8'hE0, ack); checkOutput("enAddrWAck", ack, 1'b1);
    sendByte(8'h00, ack); checkOutput("enPtrAck", ack, 1'b1);
    startCond();
    sendByte(8'hE1, ack); checkOutput("enAddrRAck", ack, 1'b1);
    checkOutput("rdBit7Drive", bus.sda_oe, 1'b1);
    i2c_en = 1'b0;
    waitClk(1);
    checkOutput("enOffOe", bus.sda_oe, 1'b0);
    base = oeCount;
    readByte(1'b1, rd);   checkOutput("enOffRead", rd, 8'hFF);
    stopCond();
    checkOutput("enOffOeCount", oeCount - base, 0);
    i2c_en = 1'b1;
    waitClk(4);
    startCond();
    sendByte(8'hE1, ack); checkOutput("enOnAddrAck", ack, 1'b1);
    readByte(1'b1, rd);   checkOutput("enOnRead", rd, 8'h5A);
    stopCond();
    checkOutput("enCfgHeld", config_regs, 64'h0000_0000_0000_005A);

    $display("[TB] out-of-range read");
    startCond();
    sendByte(8'hE0, ack); checkOutput("oorAddrAck", ack, 1'b1);
    sendByte(8'h20, ack); checkOutput("oorPtrAck", ack, 1'b1);
    startCond();
    sendByte(8'hE1, ack); checkOutput("oorRdAck", ack, 1'b1);
    readByte(1'b1, rd);   checkOutput("oorRead", rd, 8'h00);
    stopCond();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
